// File: rtl/r_release_scheduler.sv
// rtl/r_release_scheduler.sv - in-order burst release controller for the per-UID response memory
// Bursts drain strictly in issue order; tracks busy UIDs, missing-RLAST and head-wait watchdog.
module r_release_scheduler #(
   parameter int NUM_UIDS    = 16,
   parameter int ID_WIDTH    = 4,
   parameter int ORDER_DEPTH = 16,
   parameter int MAX_BEATS   = 8,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alloc_valid,
   input  logic [ID_WIDTH-1:0] alloc_uid,
   output logic                alloc_ready,
   output logic                free_req,
   output logic [ID_WIDTH-1:0] uid_to_free,
   input  logic                beat_fire,
   input  logic                beat_last,
   output logic                burst_done,
   output logic [NUM_UIDS-1:0] busy_vec,
   input  logic                err_clr,
   output logic                err_no_last,
   output logic                err_timeout
);

   localparam int AW        = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
   localparam int PW        = AW + 1;
   localparam int BW        = $clog2(MAX_BEATS + 1);
   localparam int WW        = $clog2(TIMEOUT_CYC + 1);
   localparam int UID_SPACE = 2 ** ID_WIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, STREAM = 2'd2} state_t;

   state_t              state, state_nxt;
   logic [ID_WIDTH-1:0] mem [ORDER_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr, count;
   logic [AW-1:0]       rd_idx1;
   logic [ID_WIDTH-1:0] head, uid_reg, uid_nxt;
   logic [BW-1:0]       beat_cnt;
   logic [WW-1:0]       wait_cnt;
   logic [UID_SPACE-1:0] busy_ext;
   logic [NUM_UIDS-1:0] busy_r, busy_nxt;
   logic                fifo_full, fifo_empty, acc, active;
   logic                force_pop, pop, to_hit;
   logic                err_nl_r, err_to_r;

   // UIDs beyond NUM_UIDS read as permanently busy so they are never accepted.
   genvar g;
   generate
      for (g = 0; g < UID_SPACE; g++) begin : g_busy_ext
         if (g < NUM_UIDS) begin : g_real
            assign busy_ext[g] = busy_r[g];
         end else begin : g_pad
            assign busy_ext[g] = 1'b1;
         end
      end
   endgenerate

   assign count       = wr_ptr - rd_ptr;
   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == PW'(ORDER_DEPTH));
   assign head        = mem[rd_ptr[AW-1:0]];
   assign rd_idx1     = rd_ptr[AW-1:0] + AW'(1);

   assign alloc_ready = rst_n & !fifo_full & !busy_ext[alloc_uid];
   assign acc         = alloc_valid & alloc_ready;
   assign active      = (state != IDLE);

   // A burst running MAX_BEATS beats without last is popped as if it ended.
   assign force_pop   = active & beat_fire & !beat_last & (beat_cnt == BW'(MAX_BEATS - 1));
   assign pop         = (active & beat_fire & beat_last) | force_pop;
   assign to_hit      = active & !beat_fire & (wait_cnt == WW'(TIMEOUT_CYC - 1));

   assign free_req    = active;
   assign uid_to_free = uid_reg;
   assign burst_done  = pop;
   assign busy_vec    = busy_r;
   assign err_no_last = err_nl_r;
   assign err_timeout = err_to_r;

   always_comb begin
      state_nxt = state;
      uid_nxt   = uid_reg;
      case (state)
         IDLE: begin
            if (acc || !fifo_empty) begin
               state_nxt = SEEK;
               uid_nxt   = fifo_empty ? alloc_uid : head;
            end
         end
         SEEK, STREAM: begin
            if (pop) begin
               if (count > PW'(1)) begin
                  state_nxt = SEEK;
                  uid_nxt   = mem[rd_idx1];
               end else if (acc) begin
                  state_nxt = SEEK;
                  uid_nxt   = alloc_uid;
               end else begin
                  state_nxt = IDLE;
                  uid_nxt   = '0;
               end
            end else if (beat_fire) begin
               state_nxt = STREAM;
            end
         end
         default: begin
            state_nxt = IDLE;
            uid_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      busy_nxt = busy_r;
      for (int u = 0; u < NUM_UIDS; u++) begin
         if (pop && head == ID_WIDTH'(u)) busy_nxt[u] = 1'b0;
         if (acc && alloc_uid == ID_WIDTH'(u)) busy_nxt[u] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (acc) mem[wr_ptr[AW-1:0]] <= alloc_uid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         uid_reg  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         beat_cnt <= '0;
         wait_cnt <= '0;
         busy_r   <= '0;
         err_nl_r <= 1'b0;
         err_to_r <= 1'b0;
      end else begin
         state   <= state_nxt;
         uid_reg <= uid_nxt;
         busy_r  <= busy_nxt;
         if (acc) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);

         if (pop || !active)  beat_cnt <= '0;
         else if (beat_fire)  beat_cnt <= beat_cnt + BW'(1);

         if (pop || !active || beat_fire)        wait_cnt <= '0;
         else if (wait_cnt != WW'(TIMEOUT_CYC))  wait_cnt <= wait_cnt + WW'(1);

         // A same-cycle error set overrides err_clr.
         if (force_pop)    err_nl_r <= 1'b1;
         else if (err_clr) err_nl_r <= 1'b0;

         if (to_hit)       err_to_r <= 1'b1;
         else if (err_clr) err_to_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_r_release_scheduler.sv
// tb/tb_r_release_scheduler.sv - directed self-checking bench for r_release_scheduler
// Expected release order is kept in a scoreboard queue and checked on every burst_done.
module tb_r_release_scheduler;

   localparam int NU = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alloc_valid;
   logic [IW-1:0] alloc_uid;
   logic          alloc_ready;
   logic          free_req;
   logic [IW-1:0] uid_to_free;
   logic          beat_fire;
   logic          beat_last;
   logic          burst_done;
   logic [NU-1:0] busy_vec;
   logic          err_clr;
   logic          err_no_last;
   logic          err_timeout;

   int            tests = 0;
   int            fails = 0;
   logic [IW-1:0] exp_q[$];
   logic          bd_seen, ar_seen;

   r_release_scheduler #(
      .NUM_UIDS(NU), .ID_WIDTH(IW), .ORDER_DEPTH(16), .MAX_BEATS(8), .TIMEOUT_CYC(1024)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_uid(alloc_uid), .alloc_ready(alloc_ready),
      .free_req(free_req), .uid_to_free(uid_to_free),
      .beat_fire(beat_fire), .beat_last(beat_last), .burst_done(burst_done),
      .busy_vec(busy_vec), .err_clr(err_clr),
      .err_no_last(err_no_last), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, sample comb outputs 1ns later, return at next negedge.
   task automatic cyc(input logic av, input logic [IW-1:0] au, input logic bf,
                      input logic bl, input logic ec);
      logic [IW-1:0] e;
      alloc_valid = av; alloc_uid = au; beat_fire = bf; beat_last = bl; err_clr = ec;
      #1;
      ar_seen = alloc_ready;
      bd_seen = burst_done;
      if (av && alloc_ready) exp_q.push_back(au);
      if (burst_done) begin
         check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_order", 32'(uid_to_free), 32'(e));
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; alloc_valid = 1'b0; alloc_uid = '0;
      beat_fire = 1'b0; beat_last = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_alloc_ready", 32'(alloc_ready), 0);
      check("rst_free_req",    32'(free_req), 0);
      check("rst_uid",         32'(uid_to_free), 0);
      check("rst_busy",        32'(busy_vec), 0);
      check("rst_errs",        32'({err_no_last, err_timeout, burst_done}), 0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      check("ready_after_rst", 32'(ar_seen), 1);

      // Enqueue-to-free_req latency from empty FIFO.
      cyc(1, 7, 0, 0, 0);
      check("lat_accept",  32'(ar_seen), 1);
      check("lat_free",    32'(free_req), 1);
      check("lat_uid",     32'(uid_to_free), 7);
      check("lat_busy",    32'(busy_vec), 32'h0080);
      cyc(0, 0, 1, 1, 0);
      check("lat_done",    32'(bd_seen), 1);
      check("lat_idle",    32'(free_req), 0);
      check("lat_busy_clr", 32'(busy_vec), 0);
      cyc(0, 0, 1, 1, 0);
      check("beat_in_idle_ignored", 32'(bd_seen), 0);

      // Order: UID 3 (4 beats) must drain fully before UID 5 (2 beats).
      cyc(1, 3, 0, 0, 0);
      cyc(1, 5, 0, 0, 0);
      check("ord_busy", 32'(busy_vec), 32'h0028);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0, 0);
         check("ord_uid3_hold", 32'(uid_to_free), 3);
         check("ord_no_done",   32'(bd_seen), 0);
      end
      cyc(0, 0, 1, 1, 0);
      check("ord_done3", 32'(bd_seen), 1);
      check("ord_uid5",  32'(uid_to_free), 5);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0);
      check("ord_done5", 32'(bd_seen), 1);
      check("ord_idle",  32'(free_req), 0);

      // Fill all 16 entries, then full/busy refusal boundaries.
      for (int u = 0; u < 16; u++) begin
         cyc(1, IW'(u), 0, 0, 0);
         check("fill_accept", 32'(ar_seen), 1);
      end
      check("fill_busy", 32'(busy_vec), 32'hFFFF);
      check("fill_head", 32'(uid_to_free), 0);
      cyc(1, 0, 1, 1, 0);
      check("full_pop_done",     32'(bd_seen), 1);
      check("full_realloc_refused", 32'(ar_seen), 0);
      cyc(1, 2, 0, 0, 0);
      check("busy2_refused", 32'(ar_seen), 0);
      cyc(1, 0, 0, 0, 0);
      check("realloc0_accepted", 32'(ar_seen), 1);
      for (int k = 0; k < 16; k++) cyc(0, 0, 1, 1, 0);
      check("drain_idle", 32'(free_req), 0);
      check("drain_busy", 32'(busy_vec), 0);

      // Missing last: 8 beats without last force-pop; set beats same-cycle clear.
      cyc(1, 1, 0, 0, 0);
      cyc(1, 6, 0, 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
      check("nl_7beats_noerr",  32'(err_no_last), 0);
      check("nl_7beats_nodone", 32'(bd_seen), 0);
      cyc(0, 0, 1, 0, 1);
      check("nl_forced_done", 32'(bd_seen), 1);
      check("nl_err_set",     32'(err_no_last), 1);
      check("nl_next_head",   32'(uid_to_free), 6);
      check("nl_busy",        32'(busy_vec), 32'h0040);
      cyc(0, 0, 0, 0, 1);
      check("nl_err_clr", 32'(err_no_last), 0);
      cyc(0, 0, 1, 1, 0);
      check("nl_drain6", 32'(bd_seen), 1);

      // Watchdog on head UID 4.
      cyc(1, 4, 0, 0, 0);
      repeat (1023) cyc(0, 0, 0, 0, 0);
      check("to_before", 32'(err_timeout), 0);
      cyc(0, 0, 0, 0, 0);
      check("to_set",       32'(err_timeout), 1);
      check("to_still_req", 32'(free_req), 1);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0);
      check("to_release_continues", 32'(bd_seen), 1);
      check("to_sticky", 32'(err_timeout), 1);
      cyc(0, 0, 0, 0, 1);
      check("to_clr", 32'(err_timeout), 0);

      // Reset asserted mid-STREAM.
      cyc(1, 9, 0, 0, 0);
      cyc(1, 10, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      rst_n = 1'b0;
      #1;
      check("mrst_free",  32'(free_req), 0);
      check("mrst_uid",   32'(uid_to_free), 0);
      check("mrst_busy",  32'(busy_vec), 0);
      check("mrst_ready", 32'(alloc_ready), 0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      check("mrst_idle", 32'(free_req), 0);
      cyc(1, 11, 0, 0, 0);
      check("post_rst_uid", 32'(uid_to_free), 11);
      cyc(0, 0, 1, 1, 0);
      check("post_rst_done", 32'(bd_seen), 1);
      check("sb_empty_end", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
